// File: rtl/vip_gray_pattern_gen.sv
// vip_gray_pattern_gen: synthetic 8-bit grayscale frame source (vsync/href/clken/y streams).
// Define VIP_PATTERN_NOISE_EN to overlay LFSR-driven salt-and-pepper impulse noise.
module vip_gray_pattern_gen #(
   parameter int H_ACTIVE      = 640,
   parameter int H_BLANK       = 160,
   parameter int V_ACTIVE      = 480,
   parameter int V_BLANK_LINES = 45,
   parameter int VSYNC_LINES   = 3,
   parameter int CLKEN_DIV     = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       pos_frame_vsync,
   output logic       pos_frame_href,
   output logic       pos_frame_clken,
   output logic [7:0] pos_img_y,
   output logic       frame_done
);

   localparam int H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int V_TOTAL = V_BLANK_LINES + V_ACTIVE;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DW      = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST  = DW'(CLKEN_DIV - 1);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_W   = HW'(H_ACTIVE);
   localparam logic [HW-1:0] X_LAST    = HW'(H_ACTIVE - 1);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_BLANK_W = VW'(V_BLANK_LINES);
   localparam logic [VW-1:0] V_SYNC_W  = VW'(VSYNC_LINES);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t        state, state_next;
   logic [DW-1:0] div_cnt;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [1:0]    pat_q;
   logic          tick, h_wrap, v_wrap, active, frame_start;
   logic [7:0]    x8, y8, pattern, pixel;

   always_comb begin
      tick        = (state == ST_RUN) && (div_cnt == DIV_LAST);
      h_wrap      = (h_cnt == H_LAST);
      v_wrap      = (v_cnt == V_LAST);
      active      = (h_cnt < H_ACT_W) && (v_cnt >= V_BLANK_W);
      frame_start = tick && (h_cnt == '0) && (v_cnt == '0);
      x8          = 8'(h_cnt);
      y8          = 8'(v_cnt - V_BLANK_W);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Stopping is only honoured at the frame-end wrap so a frame is never cut short.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (enable) state_next = ST_RUN;
         ST_RUN:  if (tick && h_wrap && v_wrap && !enable) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else if (state != ST_RUN) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           pat_q <= '0;
      else if (frame_start) pat_q <= pattern_sel;
   end

   always_comb begin
      case (pat_q)
         2'd0:    pattern = x8;
         2'd1:    pattern = y8;
         2'd2:    pattern = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
         default: pattern = 8'd128;
      endcase
   end

`ifdef VIP_PATTERN_NOISE_EN
   logic [15:0] lfsr;
   logic        lfsr_fb;

   always_comb lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   // Reloaded every frame so each frame carries the same noise sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             lfsr <= 16'hACE1;
      else if (state != ST_RUN || frame_start) lfsr <= 16'hACE1;
      else if (tick && active)                lfsr <= {lfsr[14:0], lfsr_fb};
   end

   always_comb begin
      pixel = pattern;
      if (lfsr[5:0] == 6'd0) pixel = lfsr[6] ? 8'hFF : 8'h00;
   end
`else
   always_comb pixel = pattern;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_frame_vsync <= 1'b0;
         pos_frame_href  <= 1'b0;
         pos_frame_clken <= 1'b0;
         pos_img_y       <= '0;
         frame_done      <= 1'b0;
      end else if (state != ST_RUN) begin
         pos_frame_vsync <= 1'b0;
         pos_frame_href  <= 1'b0;
         pos_frame_clken <= 1'b0;
         pos_img_y       <= '0;
         frame_done      <= 1'b0;
      end else begin
         pos_frame_vsync <= (v_cnt < V_SYNC_W);
         pos_frame_href  <= active;
         pos_frame_clken <= tick && active;
         pos_img_y       <= active ? pixel : '0;
         frame_done      <= tick && active && (h_cnt == X_LAST) && v_wrap;
      end
   end

endmodule

// File: tb/tb_vip_gray_pattern_gen.sv
// Directed bench for vip_gray_pattern_gen with a small 8x4 frame (12 slots x 7 lines, 2 clk per slot).
// Frame = 168 clk; samples taken on the falling edge, index 0 = first sample with vsync high.
module tb_vip_gray_pattern_gen;

   localparam int FRAME = 168;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [1:0] pattern_sel;
   logic       pos_frame_vsync, pos_frame_href, pos_frame_clken, frame_done;
   logic [7:0] pos_img_y;

   int checks = 0;
   int errors = 0;

   int n_clk, n_href, n_vs, n_fd, fd_idx, fd_with_clk, y_leak;
   int run_min, run_max, gap_min, gap_max, n_runs;
   logic [7:0] pix [64];
   logic [7:0] pix_a [64];

   vip_gray_pattern_gen #(
      .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4),
      .V_BLANK_LINES(3), .VSYNC_LINES(1), .CLKEN_DIV(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
      .pos_frame_vsync(pos_frame_vsync), .pos_frame_href(pos_frame_href),
      .pos_frame_clken(pos_frame_clken), .pos_img_y(pos_img_y), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Records one frame of outputs, optionally changing pattern_sel / dropping enable at a sample.
   task automatic capture(input int chg_k, input logic [1:0] chg_val, input int en_k);
      int   run, gap;
      logic prev_h;
      n_clk = 0; n_href = 0; n_vs = 0; n_fd = 0; fd_idx = -1; fd_with_clk = 0; y_leak = 0;
      run_min = 1000; run_max = 0; gap_min = 1000; gap_max = 0; n_runs = 0;
      run = 0; gap = 0; prev_h = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         if (pos_frame_href) begin
            if (!prev_h) begin
               if (n_runs > 0) begin
                  if (gap < gap_min) gap_min = gap;
                  if (gap > gap_max) gap_max = gap;
               end
               n_runs++;
               run = 0;
            end
            run++;
            n_href++;
         end else begin
            if (prev_h) begin
               if (run < run_min) run_min = run;
               if (run > run_max) run_max = run;
               gap = 0;
            end
            gap++;
         end
         prev_h = pos_frame_href;
         if (pos_frame_clken) begin
            if (n_clk < 64) pix[n_clk] = pos_img_y;
            n_clk++;
         end
         if (!pos_frame_href && pos_img_y != 8'd0) y_leak++;
         if (pos_frame_vsync) n_vs++;
         if (frame_done) begin
            n_fd++;
            fd_idx = k;
            if (pos_frame_clken) fd_with_clk++;
         end
         if (k == chg_k) pattern_sel = chg_val;
         if (k == en_k) enable = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      int rise;
      rst_n = 1'b0; enable = 1'b1; pattern_sel = 2'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({pos_frame_vsync, pos_frame_href, pos_frame_clken, pos_img_y, frame_done} !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 000",
                  {pos_frame_vsync, pos_frame_href, pos_frame_clken, pos_img_y, frame_done});
      end
      rst_n = 1'b1;
      rise = -1;
      for (int i = 1; i <= 4 && rise < 0; i++) begin
         @(negedge clk);
         if (pos_frame_vsync) rise = i;
      end
      checks++;
      if (rise !== 2) begin errors++; $display("FAIL reset_vsync_rise: got %0d clk expected 2", rise); end
   endtask

   task automatic test_h_ramp;
      int bad;
      capture(-1, 2'd0, -1);
      checks++;
      if (n_clk !== 32) begin errors++; $display("FAIL hramp_clken_count: got %0d expected 32", n_clk); end
      bad = 0;
      for (int n = 0; n < 32; n++) if (pix[n] !== 8'(n % 8)) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL hramp_pixels: got %0d wrong expected 0", bad); end
      checks++;
      if (n_href !== 64 || run_min !== 16 || run_max !== 16) begin
         errors++;
         $display("FAIL hramp_href: got total %0d run %0d..%0d expected 64 run 16..16", n_href, run_min, run_max);
      end
      checks++;
      if (gap_min !== 8 || gap_max !== 8) begin
         errors++; $display("FAIL hramp_href_gap: got %0d..%0d expected 8..8", gap_min, gap_max);
      end
      checks++;
      if (n_vs !== 24) begin errors++; $display("FAIL hramp_vsync_len: got %0d expected 24", n_vs); end
      checks++;
      if (n_fd !== 1 || fd_idx !== 159 || fd_with_clk !== 1) begin
         errors++;
         $display("FAIL hramp_frame_done: got count %0d at %0d with_clken %0d expected 1 at 159 with_clken 1",
                  n_fd, fd_idx, fd_with_clk);
      end
      checks++;
      if (y_leak !== 0) begin errors++; $display("FAIL hramp_y_blank: got %0d nonzero expected 0", y_leak); end
   endtask

   task automatic test_v_ramp;
      int bad;
      pattern_sel = 2'd1;
      capture(-1, 2'd0, -1);
      bad = 0;
      for (int n = 0; n < 32; n++) if (pix[n] !== 8'(n / 8)) bad++;
      checks++;
      if (n_clk !== 32 || bad !== 0) begin
         errors++; $display("FAIL vramp_pixels: got %0d clken %0d wrong expected 32 clken 0 wrong", n_clk, bad);
      end
   endtask

   task automatic test_pattern_switch;
      int bad;
      pattern_sel = 2'd0;
      capture(96, 2'd2, -1);
      bad = 0;
      for (int n = 0; n < 32; n++) if (pix[n] !== 8'(n % 8)) bad++;
      checks++;
      if (n_clk !== 32 || bad !== 0) begin
         errors++; $display("FAIL switch_same_frame: got %0d clken %0d wrong expected 32 clken 0 wrong", n_clk, bad);
      end
      capture(-1, 2'd0, -1);
      bad = 0;
      for (int n = 0; n < 32; n++) if (pix[n] !== 8'd0) bad++;
      checks++;
      if (n_clk !== 32 || bad !== 0) begin
         errors++; $display("FAIL switch_next_frame: got %0d clken %0d wrong expected 32 clken 0 wrong", n_clk, bad);
      end
   endtask

   task automatic test_enable_drop;
      int busy, rise;
      pattern_sel = 2'd0;
      capture(-1, 2'd0, 120);
      checks++;
      if (n_clk !== 32 || n_fd !== 1) begin
         errors++; $display("FAIL drop_frame_complete: got clken %0d done %0d expected 32 and 1", n_clk, n_fd);
      end
      busy = 0;
      for (int i = 0; i < 40; i++) begin
         if (pos_frame_vsync || pos_frame_href || pos_frame_clken) busy++;
         @(negedge clk);
      end
      checks++;
      if (busy !== 0) begin errors++; $display("FAIL drop_idle_quiet: got %0d active samples expected 0", busy); end
      enable = 1'b1;
      rise = -1;
      for (int i = 1; i <= 4 && rise < 0; i++) begin
         @(negedge clk);
         if (pos_frame_vsync) rise = i;
      end
      checks++;
      if (rise !== 2) begin errors++; $display("FAIL drop_restart: got %0d clk expected 2", rise); end
   endtask

   task automatic test_reset_mid_line;
      int rise, early, bad;
      repeat (100) @(negedge clk);
      checks++;
      if (pos_frame_href !== 1'b1 || pos_img_y !== 8'd2) begin
         errors++; $display("FAIL midline_pre: got href %b y %0d expected href 1 y 2", pos_frame_href, pos_img_y);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pos_frame_vsync, pos_frame_href, pos_frame_clken, pos_img_y, frame_done} !== 12'h000) begin
         errors++;
         $display("FAIL midline_async_clear: got %h expected 000",
                  {pos_frame_vsync, pos_frame_href, pos_frame_clken, pos_img_y, frame_done});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rise = -1; early = 0;
      for (int i = 1; i <= 6 && rise < 0; i++) begin
         @(negedge clk);
         if (pos_frame_vsync) rise = i;
         else if (pos_frame_href || pos_frame_clken) early++;
      end
      checks++;
      if (rise !== 2 || early !== 0) begin
         errors++; $display("FAIL midline_restart: got rise %0d early %0d expected rise 2 early 0", rise, early);
      end
      capture(-1, 2'd0, -1);
      bad = 0;
      for (int n = 0; n < 32; n++) if (pix[n] !== 8'(n % 8)) bad++;
      checks++;
      if (n_clk !== 32 || bad !== 0 || n_fd !== 1) begin
         errors++;
         $display("FAIL midline_full_frame: got clken %0d wrong %0d done %0d expected 32 0 1", n_clk, bad, n_fd);
      end
   endtask

   task automatic test_flat;
      int bad, diff;
      pattern_sel = 2'd3;
      capture(-1, 2'd0, -1);
      for (int n = 0; n < 64; n++) pix_a[n] = pix[n];
      checks++;
      if (n_clk !== 32) begin errors++; $display("FAIL flat_clken_count: got %0d expected 32", n_clk); end
      capture(-1, 2'd0, -1);
      bad = 0; diff = 0;
      for (int n = 0; n < 32; n++) begin
         if (pix[n] !== pix_a[n]) diff++;
`ifdef VIP_PATTERN_NOISE_EN
         if (pix[n] !== 8'd128 && pix[n] !== 8'd0 && pix[n] !== 8'd255) bad++;
`else
         if (pix[n] !== 8'd128 || pix_a[n] !== 8'd128) bad++;
`endif
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL flat_values: got %0d wrong expected 0", bad); end
      checks++;
      if (diff !== 0) begin errors++; $display("FAIL flat_repeat: got %0d differing expected 0", diff); end
   endtask

   initial begin
      test_reset;
      test_h_ramp;
      test_v_ramp;
      test_pattern_switch;
      test_enable_drop;
      test_reset_mid_line;
      test_flat;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
